// File: rtl/right_shift_ctrl.sv
// Serial right-shift sequencer: valid/ready in, one bit per clock, valid/ready out.
// Optional sticky output (OR of shifted-out bits) enabled by RIGHT_SHIFT_STICKY_EN.
module right_shift_ctrl #(
    parameter int WIDTH = 4,
    parameter int AMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AMT_W-1:0] in_amt,
    input  logic             in_arith,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
`ifdef RIGHT_SHIFT_STICKY_EN
    output logic             sticky,
`endif
    output logic             busy
);

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    state_t           state, state_next;
    logic [WIDTH-1:0] shreg;
    logic [AMT_W-1:0] cnt;
    logic [AMT_W-1:0] amt_clamped;
    logic             fill;
    logic             accept;

    assign in_ready    = (state == IDLE) && !rst;
    assign accept      = in_valid && in_ready;
    assign amt_clamped = (in_amt > AMT_W'(WIDTH)) ? AMT_W'(WIDTH) : in_amt;
    assign out_valid   = (state == DONE);
    assign out_data    = shreg;
    assign busy        = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:  if (accept) state_next = (amt_clamped == '0) ? DONE : SHIFT;
            SHIFT: if (cnt == AMT_W'(1)) state_next = DONE;
            DONE:  if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Shift register and count only move on accept or while shifting, so the
    // result holds through DONE and after the output handshake.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            shreg <= '0;
            cnt   <= '0;
            fill  <= 1'b0;
        end else if (accept) begin
            shreg <= in_data;
            cnt   <= amt_clamped;
            fill  <= in_arith & in_data[WIDTH-1];
        end else if (state == SHIFT) begin
            shreg <= {fill, shreg[WIDTH-1:1]};
            cnt   <= cnt - AMT_W'(1);
        end
    end

`ifdef RIGHT_SHIFT_STICKY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                 sticky <= 1'b0;
        else if (accept)         sticky <= 1'b0;
        else if (state == SHIFT) sticky <= sticky | shreg[0];
    end
`endif

endmodule
